// File: rtl/circle_path_ctrl.sv
// circle_path_ctrl: moves a single circle glyph around the perimeter of a
// multi-digit 7-segment display. The top row is walked left-to-right and the
// bottom row right-to-left (clockwise), or in reverse when dir_i is set.
// row_o and digit_en_o drive the per-digit circle_on_seg encoders directly.
// Every output is registered, so no input reaches an output combinationally.
module circle_path_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int STEP_CYCLES = 50000000,
  parameter int POS_W       = $clog2(2 * NUM_DIGITS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  input  logic                  dir_i,
  input  logic                  step_i,
  output logic                  row_o,
  output logic [NUM_DIGITS-1:0] digit_en_o,
  output logic [POS_W-1:0]      pos_o,
  output logic                  step_o
);

  // Prescaler width. Keep at least one bit so STEP_CYCLES = 1 still elaborates;
  // in that case the counter sits at its terminal value and fires every cycle.
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(2 * NUM_DIGITS - 1);
  localparam logic [POS_W-1:0] POS_SPLIT = POS_W'(NUM_DIGITS);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    advance;
  logic [POS_W-1:0]        pos_d;
  logic [POS_W-1:0]        digit_idx;
  logic                    row_d;
  logic [NUM_DIGITS-1:0]   digit_en_d;

  // Next-state, prescaler and advance strobe. The strobe comes from the
  // registered state, so a run_i change only takes effect one cycle later.
  always_comb begin
    // NOTE: every signal written here gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    advance = 1'b0;
    case (state_q)
      ST_STOP: begin
        // Prescaler is held at zero so each RUN entry waits a full interval.
        if (run_i) state_d = ST_RUN;
        advance = step_i;
      end
      ST_RUN: begin
        if (!run_i) state_d = ST_STOP;
        if (cnt_q == CNT_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Next position and its mapping onto the display row and one-hot digit.
  // dir_i only matters in the advance cycle, so it can change freely between
  // steps without moving the circle.
  always_comb begin
    pos_d = pos_o;
    if (advance) begin
      if (dir_i) begin
        pos_d = (pos_o == '0) ? POS_LAST : pos_o - 1'b1;
      end else begin
        pos_d = (pos_o == POS_LAST) ? '0 : pos_o + 1'b1;
      end
    end
    // Top row: digit index equals position. Bottom row: walked back from the
    // rightmost digit, so the corners repeat the same digit on both rows.
    row_d     = (pos_d < POS_SPLIT);
    digit_idx = row_d ? pos_d : (POS_LAST - pos_d);
    digit_en_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_en_d[k] = (digit_idx == POS_W'(k));
    end
  end

  // Mode register and prescaler.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs; step_o marks the first cycle of each new position.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_o      <= '0;
      row_o      <= 1'b1;
      digit_en_o <= NUM_DIGITS'(1);
      step_o     <= 1'b0;
    end else begin
      pos_o      <= pos_d;
      row_o      <= row_d;
      digit_en_o <= digit_en_d;
      step_o     <= advance;
    end
  end

endmodule

// File: tb/tb_circle_path_ctrl.sv
// Directed bench for circle_path_ctrl with NUM_DIGITS = 4, STEP_CYCLES = 3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_circle_path_ctrl;

  localparam int N  = 4;
  localparam int SC = 3;
  localparam int PW = $clog2(2 * N);

  logic          clk    = 1'b0;
  logic          rst_ni = 1'b0;
  logic          run    = 1'b0;
  logic          dir    = 1'b0;
  logic          step   = 1'b0;
  logic          row;
  logic [N-1:0]  digit_en;
  logic [PW-1:0] pos;
  logic          step_pulse;

  int total = 0;
  int bad   = 0;

  // Hand-derived display mapping for positions 0..7.
  logic [N-1:0] en_tab  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic         row_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  circle_path_ctrl #(
    .NUM_DIGITS  (N),
    .STEP_CYCLES (SC)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .run_i      (run),
    .dir_i      (dir),
    .step_i     (step),
    .row_o      (row),
    .digit_en_o (digit_en),
    .pos_o      (pos),
    .step_o     (step_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [PW-1:0] e_pos,
                           input logic e_row, input logic [N-1:0] e_en,
                           input logic e_step);
    total++;
    assert (pos === e_pos) else begin
      bad++;
      $error("FAIL %s pos_o got=%0d want=%0d", tag, pos, e_pos);
    end
    total++;
    assert (row === e_row) else begin
      bad++;
      $error("FAIL %s row_o got=%b want=%b", tag, row, e_row);
    end
    total++;
    assert (digit_en === e_en) else begin
      bad++;
      $error("FAIL %s digit_en_o got=%b want=%b", tag, digit_en, e_en);
    end
    total++;
    assert (step_pulse === e_step) else begin
      bad++;
      $error("FAIL %s step_o got=%b want=%b", tag, step_pulse, e_step);
    end
  endtask

  task automatic check_at(input string tag, input int p, input logic e_step);
    check_out(tag, p[PW-1:0], row_tab[p], en_tab[p], e_step);
  endtask

  initial begin
    int p;
    int gap;

    // Reset held, then released; nothing moves while run_i is low.
    #23;
    check_at("in_reset", 0, 1'b0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_at("idle", 0, 1'b0);
    end

    // Clockwise run: first step 4 cycles after run rises, then every 3.
    run = 1'b1;
    dir = 1'b0;
    tick();
    check_at("cw_enter", 0, 1'b0);
    p = 0;
    for (int s = 0; s < 8; s++) begin
      repeat (2) begin
        tick();
        check_at("cw_gap", p, 1'b0);
      end
      tick();
      p = (p + 1) % 8;
      check_at("cw_step", p, 1'b1);
    end

    // Counter-clockwise from position 0: wraps to 7, then 6.
    dir = 1'b1;
    for (int s = 0; s < 2; s++) begin
      repeat (2) begin
        tick();
        check_at("ccw_gap", p, 1'b0);
      end
      tick();
      p = (p + 7) % 8;
      check_at("ccw_step", p, 1'b1);
    end

    // Drop run one cycle before the next step is due: no step follows.
    tick();
    check_at("pre_drop", 6, 1'b0);
    run = 1'b0;
    repeat (4) begin
      tick();
      check_at("stopped", 6, 1'b0);
    end

    // Restart; flip direction mid-interval. Step lands 4 cycles later, clockwise.
    run = 1'b1;
    tick();
    check_at("restart", 6, 1'b0);
    dir = 1'b0;
    repeat (2) begin
      tick();
      check_at("dir_hold", 6, 1'b0);
    end
    tick();
    check_at("dir_step", 7, 1'b1);

    // Single steps while stopped, with random gaps between pulses.
    run = 1'b0;
    tick();
    check_at("stop2", 7, 1'b0);
    p = 7;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      p = (p + 1) % 8;
      check_at("sstep", p, 1'b1);
      gap = $urandom_range(1, 4);
      repeat (gap) begin
        tick();
        check_at("sstep_gap", p, 1'b0);
      end
    end

    // step_i is ignored in RUN: only the prescaler step appears.
    run = 1'b1;
    tick();
    check_at("run_enter", 2, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_at("run_step_ign", 2, 1'b0);
    tick();
    check_at("run_gap", 2, 1'b0);
    tick();
    check_at("run_auto", 3, 1'b1);

    // run_i rising together with step_i in STOP: step taken, then full interval.
    run = 1'b0;
    tick();
    check_at("stop3", 3, 1'b0);
    run  = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    check_at("sim_step", 4, 1'b1);
    repeat (2) begin
      tick();
      check_at("sim_gap", 4, 1'b0);
    end
    tick();
    check_at("sim_auto", 5, 1'b1);

    // Reset while prescaler = 2 at position 5, just before a step is due.
    tick();
    check_at("pre_rst_a", 5, 1'b0);
    tick();
    check_at("pre_rst_b", 5, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check_at("async_rst", 0, 1'b0);
    run = 1'b0;
    tick();
    check_at("rst_hold", 0, 1'b0);
    rst_ni = 1'b1;
    tick();
    check_at("post_rst", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
